// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// The optional feature macro DMEM_ARB_ALIGN_CHECK_EN is consumed by dmem_arbiter.
package dmem_arb_pkg;

   localparam int unsigned DMEM_ADDR_W = 64;
   localparam int unsigned DMEM_DATA_W = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; ptr names the master that wins a tie.
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       ptr,
   output logic       winner,
   output logic       valid
);

   always_comb begin
      valid  = |req;
      winner = M0;
      if (req == 2'b11) begin
         winner = ptr;
      end else if (req[1]) begin
         winner = M1;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter and 3-cycle access sequencer for the data memory.
// Define DMEM_ARB_ALIGN_CHECK_EN to add m0_err/m1_err and suppress misaligned accesses.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = DMEM_ADDR_W,
   parameter int unsigned DATA_W = DMEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
`ifdef DMEM_ARB_ALIGN_CHECK_EN
   output logic              m0_err,
   output logic              m1_err,
`endif
   output logic              busy
);

   arb_state_t        state_q, state_d;
   logic              rr_ptr;
   logic              owner_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              mis_q;
   logic              winner;
   logic              arb_valid;
   logic              accept;

   rr_arb2 u_rr_arb2 (
      .req    ({m1_req, m0_req}),
      .ptr    (rr_ptr),
      .winner (winner),
      .valid  (arb_valid)
   );

   assign accept = (state_q == IDLE) && arb_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (arb_valid) state_d = ACCESS;
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr  <= M0;
         owner_q <= M0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            owner_q <= winner;
            rr_ptr  <= ~winner;
            we_q    <= (winner == M1) ? m1_we    : m0_we;
            addr_q  <= (winner == M1) ? m1_addr  : m0_addr;
            wdata_q <= (winner == M1) ? m1_wdata : m0_wdata;
         end
         // Writes and suppressed accesses answer with zero data.
         if (state_q == ACCESS) begin
            rdata_q <= (we_q || mis_q) ? '0 : mem_rdata;
         end
      end
   end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mis_q <= 1'b0;
      end else if (accept) begin
         mis_q <= (winner == M1) ? (m1_addr[2:0] != 3'd0) : (m0_addr[2:0] != 3'd0);
      end
   end
`else
   assign mis_q = 1'b0;
`endif

   always_comb begin
      m0_gnt    = 1'b0;
      m1_gnt    = 1'b0;
      m0_rvalid = 1'b0;
      m1_rvalid = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      m0_err    = 1'b0;
      m1_err    = 1'b0;
`endif
      unique case (state_q)
         ACCESS: begin
            m0_gnt    = (owner_q == M0);
            m1_gnt    = (owner_q == M1);
            mem_read  = !we_q && !mis_q;
            mem_write = we_q && !mis_q;
         end
         RESP: begin
            m0_rvalid = (owner_q == M0);
            m1_rvalid = (owner_q == M1);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            m0_err    = (owner_q == M0) && mis_q;
            m1_err    = (owner_q == M1) && mis_q;
`endif
         end
         default: ;
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign rdata     = rdata_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter against a transaction-timeline model.
// Exercises the m0_err/m1_err path when DMEM_ARB_ALIGN_CHECK_EN is defined.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        m0_req, m0_we, m0_gnt, m0_rvalid;
   logic        m1_req, m1_we, m1_gnt, m1_rvalid;
   logic [63:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [63:0] rdata, mem_addr, mem_wdata, mem_rdata;
   logic        mem_read, mem_write, busy;
   logic [1:0]  err_vec;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
   logic        m0_err, m1_err;
   assign err_vec = {m0_err, m1_err};
`else
   assign err_vec = 2'b00;
`endif

   logic        p_req[2];
   logic        p_we[2];
   logic [63:0] p_addr[2];
   logic [63:0] p_wdata[2];

   assign m0_req = p_req[0];
   assign m0_we = p_we[0];
   assign m0_addr = p_addr[0];
   assign m0_wdata = p_wdata[0];
   assign m1_req = p_req[1];
   assign m1_we = p_we[1];
   assign m1_addr = p_addr[1];
   assign m1_wdata = p_wdata[1];

   logic [6:0] ctl;
   assign ctl = {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_read, mem_write, busy};

   dmem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .m0_req    (m0_req),
      .m0_we     (m0_we),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m0_gnt    (m0_gnt),
      .m0_rvalid (m0_rvalid),
      .m1_req    (m1_req),
      .m1_we     (m1_we),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_gnt    (m1_gnt),
      .m1_rvalid (m1_rvalid),
      .rdata     (rdata),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      .m0_err    (m0_err),
      .m1_err    (m1_err),
`endif
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Environment memory: 32 words, bits [2:0] ignored, combinational read.
   logic [63:0] dmem[32];
   assign mem_rdata = dmem[mem_addr[7:3]];
   always @(posedge clk) if (mem_write) dmem[mem_addr[7:3]] <= mem_wdata;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   logic [63:0] ref_mem[32];
   bit          pend[2];
   int          rel_k[2];
   bit          pref;
   int          free_at;
   bit          t_act, t_m, t_we, t_mis;
   int          t_k;
   logic [63:0] t_addr, t_wdata, t_rd;
   logic [63:0] exp_maddr, exp_mwdata, exp_rdata;

   task automatic dir_txn(input bit m, input bit we, input logic [63:0] a, input logic [63:0] d,
                          input logic [63:0] exp_rd, input bit exp_err);
      p_req[m] = 1'b1;
      p_we[m] = we;
      p_addr[m] = a;
      p_wdata[m] = d;
      @(negedge clk);
      check("d_acc", {57'b0, ctl}, {57'b0, !m, m, 2'b00, !we && !exp_err, we && !exp_err, 1'b1});
      check("d_addr", mem_addr, a);
      check("d_wdata", mem_wdata, d);
      @(negedge clk);
      p_req[m] = 1'b0;
      check("d_resp", {57'b0, ctl}, {57'b0, 2'b00, !m, m, 2'b00, 1'b1});
      check("d_rdata", rdata, exp_rd);
      if (ALIGN_EN) check("d_err", {62'b0, err_vec}, {62'b0, exp_err && !m, exp_err && m});
      @(negedge clk);
      check("d_idle", {57'b0, ctl}, 64'd0);
   endtask

   task automatic gen_cmd(input int i);
      logic [4:0] idx;
      logic [2:0] off;
      idx = 5'($urandom_range(0, 31));
      off = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      p_we[i] = 1'($urandom_range(0, 1));
      p_addr[i] = {56'b0, idx, off};
      p_wdata[i] = {$urandom, $urandom};
   endtask

   function automatic bit wants(input int i, input int k);
      if (k < 30) return 1'b1;
      if (k < 60) return (i == 1);
      return ($urandom_range(0, 2) == 0);
   endfunction

   task automatic model_check(input int k);
      bit in_acc, in_resp;
      in_acc  = t_act && (k == t_k + 1);
      in_resp = t_act && (k == t_k + 2);
      if (in_acc) begin
         exp_maddr  = t_addr;
         exp_mwdata = t_wdata;
      end
      if (in_resp) exp_rdata = t_rd;
      check("ctl", {57'b0, ctl}, {57'b0, in_acc && !t_m, in_acc && t_m, in_resp && !t_m,
                                  in_resp && t_m, in_acc && !t_we && !t_mis,
                                  in_acc && t_we && !t_mis, in_acc || in_resp});
      check("mem_addr", mem_addr, exp_maddr);
      check("mem_wdata", mem_wdata, exp_mwdata);
      check("rdata", rdata, exp_rdata);
      if (ALIGN_EN) check("err", {62'b0, err_vec},
                          {62'b0, in_resp && t_mis && !t_m, in_resp && t_mis && t_m});
      if (in_acc) begin
         if (t_we && !t_mis) ref_mem[t_addr[7:3]] = t_wdata;
         rel_k[t_m] = k + 1;
      end
   endtask

   task automatic drive(input int k);
      for (int i = 0; i < 2; i++) begin
         if (pend[i] && rel_k[i] >= 0 && k >= rel_k[i]) begin
            pend[i] = 1'b0;
            rel_k[i] = -1;
         end
         if (!pend[i] && wants(i, k)) begin
            gen_cmd(i);
            pend[i] = 1'b1;
         end
         p_req[i] = pend[i];
      end
   endtask

   task automatic accept(input int k);
      bit w;
      if (k >= free_at && (pend[0] || pend[1])) begin
         w = (pend[0] && pend[1]) ? pref : pend[1];
         pref = !w;
         t_act = 1'b1;
         t_k = k;
         t_m = w;
         t_we = p_we[w];
         t_addr = p_addr[w];
         t_wdata = p_wdata[w];
         t_mis = ALIGN_EN && (t_addr[2:0] != 3'd0);
         t_rd = (t_we || t_mis) ? 64'd0 : ref_mem[t_addr[7:3]];
         free_at = k + 3;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         p_req[i] = 1'b0;
         p_we[i] = 1'b0;
         p_addr[i] = '0;
         p_wdata[i] = '0;
      end
      for (int i = 0; i < 32; i++) begin
         dmem[i] = '0;
         ref_mem[i] = '0;
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("rst_ctl", {57'b0, ctl}, 64'd0);
      check("rst_rdata", rdata, 64'd0);
      check("rst_maddr", mem_addr, 64'd0);
      check("rst_err", {62'b0, err_vec}, 64'd0);

      dir_txn(1'b0, 1'b1, 64'h40, 64'hDEADBEEF_CAFEF00D, 64'd0, 1'b0);
      dir_txn(1'b0, 1'b0, 64'h40, 64'd0, 64'hDEADBEEF_CAFEF00D, 1'b0);
      if (ALIGN_EN) begin
         dir_txn(1'b0, 1'b1, 64'h43, 64'h1111, 64'd0, 1'b1);
         dir_txn(1'b0, 1'b0, 64'h40, 64'd0, 64'hDEADBEEF_CAFEF00D, 1'b0);
      end

      // Reset asserted mid-ACCESS: the write must not land.
      p_req[0] = 1'b1;
      p_we[0] = 1'b1;
      p_addr[0] = 64'h80;
      p_wdata[0] = 64'h1234;
      @(posedge clk);
      #1;
      check("ra_acc", {57'b0, ctl}, {57'b0, 7'b1000011});
      #2 rst_n = 1'b0;
      #1;
      check("ra_ctl", {57'b0, ctl}, 64'd0);
      check("ra_addr", mem_addr, 64'd0);
      check("ra_wdata", mem_wdata, 64'd0);
      check("ra_rdata", rdata, 64'd0);
      @(negedge clk);
      p_req[0] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("ra_post", {57'b0, ctl}, 64'd0);
      end
      dir_txn(1'b0, 1'b0, 64'h80, 64'd0, 64'd0, 1'b0);
      dir_txn(1'b1, 1'b0, 64'h40, 64'd0, 64'hDEADBEEF_CAFEF00D, 1'b0);

      // Randomized phase from a fresh reset.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      ref_mem[8] = 64'hDEADBEEF_CAFEF00D;
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      rel_k[0] = -1;
      rel_k[1] = -1;
      pref = 1'b0;
      free_at = 0;
      t_act = 1'b0;
      t_k = -10;
      exp_maddr = '0;
      exp_mwdata = '0;
      exp_rdata = '0;
      for (int k = 0; k < 400; k++) begin
         model_check(k);
         drive(k);
         accept(k);
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
